// File: rtl/mxv_sequencer_if.sv
// Command, stall and row-result handshake bundle
// between the MxV command side and the sequencer.
interface mxv_sequencer_if #(
  parameter int WORD_LENGTH = 8
);
  logic                   start;
  logic [WORD_LENGTH-1:0] matrix_size;
  logic                   abort;
  logic                   hold;
  logic                   result_ready;
  logic [WORD_LENGTH-1:0] row_idx;
  logic [WORD_LENGTH-1:0] col_idx;
  logic                   acc_clear;
  logic                   mac_en;
  logic                   result_valid;
  logic                   busy;
  logic                   done;
  logic                   size_error;

  modport master (
    output start, matrix_size, abort,
    output hold, result_ready,
    input  row_idx, col_idx, acc_clear,
    input  mac_en, result_valid, busy,
    input  done, size_error
  );

  modport slave (
    input  start, matrix_size, abort,
    input  hold, result_ready,
    output row_idx, col_idx, acc_clear,
    output mac_en, result_valid, busy,
    output done, size_error
  );
endinterface

// File: rtl/mxv_sequencer.sv
// Row/column sequencer for the MxV datapath:
// clears, accumulates and hands off one row at a time.
module mxv_sequencer #(
  parameter int WORD_LENGTH = 8
) (
  input logic           clk,
  input logic           reset,
  mxv_sequencer_if.slave bus
);
  typedef logic [WORD_LENGTH-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    WRITE,
    DONE
  } state_t;

  state_t state, state_nxt;
  word_t  row, row_nxt;
  word_t  col, col_nxt;
  word_t  size, size_nxt;
  word_t  last;
  logic   serr, serr_nxt;

  // size is never 0 outside IDLE, so last cannot wrap while used
  assign last = size - word_t'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      size  <= '0;
      serr  <= 1'b0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
      size  <= size_nxt;
      serr  <= serr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    size_nxt  = size;
    serr_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.matrix_size != '0) begin
            size_nxt  = bus.matrix_size;
            row_nxt   = '0;
            col_nxt   = '0;
            state_nxt = CLEAR;
          end else begin
            serr_nxt = 1'b1;
          end
        end
      end
      CLEAR: state_nxt = RUN;
      RUN: begin
        if (!bus.hold) begin
          if (col == last) begin
            col_nxt   = '0;
            state_nxt = WRITE;
          end else begin
            col_nxt = col + word_t'(1);
          end
        end
      end
      WRITE: begin
        if (bus.result_ready) begin
          if (row == last) begin
            state_nxt = DONE;
          end else begin
            row_nxt   = row + word_t'(1);
            state_nxt = CLEAR;
          end
        end
      end
      DONE: begin
        row_nxt   = '0;
        col_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.abort) begin
      state_nxt = IDLE;
      row_nxt   = '0;
      col_nxt   = '0;
      serr_nxt  = 1'b0;
    end
  end

  assign bus.row_idx      = row;
  assign bus.col_idx      = col;
  assign bus.acc_clear    = (state == CLEAR);
  assign bus.mac_en       = (state == RUN) && !bus.hold;
  assign bus.result_valid = (state == WRITE);
  assign bus.busy         = (state != IDLE);
  assign bus.done         = (state == DONE);
  assign bus.size_error   = serr;
endmodule
